// File: rtl/sprite_pkg.sv
// Object-descriptor layout, identity codes and manager state encoding shared
// by obj_manager and display.
package sprite_pkg;

  localparam int DESC_W    = 26;
  localparam int FRAME_LSB = 23;
  localparam int FRAME_W   = 3;
  localparam int ID_LSB    = 21;
  localparam int ID_W      = 2;
  localparam int HPOS_LSB  = 10;
  localparam int HPOS_W    = 11;
  localparam int VPOS_LSB  = 0;
  localparam int VPOS_W    = 10;

  localparam int NUM_SLOTS = 5;
  localparam int SCREEN_W  = 1024;

  localparam logic [ID_W-1:0] ID_COLL  = 2'd0;
  localparam logic [ID_W-1:0] ID_SHARK = 2'd1;

  typedef logic [DESC_W-1:0] desc_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_UPDATE  = 2'd1,
    ST_PUBLISH = 2'd2
  } mgr_state_e;

  function automatic desc_t pack_desc(input logic [FRAME_W-1:0] frame,
                                      input logic [ID_W-1:0]    id,
                                      input logic [HPOS_W-1:0]  hpos,
                                      input logic [VPOS_W-1:0]  vpos);
    return {frame, id, hpos, vpos};
  endfunction

endpackage

// File: rtl/obj_slot_step.sv
// Next-descriptor function for one slot per frame: retire, scroll left, and
// advance the animation frame.
module obj_slot_step
  import sprite_pkg::*;
#(
  parameter int ANIM_FRAMES = 3
) (
  input  logic [DESC_W-1:0] desc_i,
  input  logic [3:0]        speed_i,
  input  logic              step_i,
  input  logic              clear_i,
  output logic [DESC_W-1:0] desc_o
);

  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(ANIM_FRAMES - 1);

  logic [FRAME_W-1:0] frame;
  logic [HPOS_W-1:0]  hpos;
  logic [HPOS_W-1:0]  speed_ext;

  assign frame     = desc_i[FRAME_LSB +: FRAME_W];
  assign hpos      = desc_i[HPOS_LSB +: HPOS_W];
  assign speed_ext = {{(HPOS_W-4){1'b0}}, speed_i};

  // NOTE: desc_o gets a default before any branch so no latch is inferred.
  always_comb begin
    desc_o = desc_i;
    if (desc_i != '0) begin
      if (clear_i || (hpos < speed_ext)) begin
        desc_o = '0;
      end else begin
        desc_o[HPOS_LSB +: HPOS_W] = hpos - speed_ext;
        if (step_i) begin
          desc_o[FRAME_LSB +: FRAME_W] = (frame == FRAME_LAST) ? '0 : frame + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/obj_manager.sv
// Five-slot object manager: accepts spawns, walks every slot once per frame
// tick, then publishes the descriptors consumed by display.
module obj_manager
  import sprite_pkg::*;
#(
  parameter int SPAWN_X     = 1023,
  parameter int ANIM_FRAMES = 3,
  parameter int ANIM_DIV    = 8
) (
  input  logic        vclock,
  input  logic        reset_n,
  input  logic        vsync,
  input  logic [3:0]  scroll_speed,
  input  logic        spawn_valid,
  input  logic [1:0]  spawn_type,
  input  logic [9:0]  spawn_vpos,
  output logic        spawn_ready,
  input  logic [4:0]  clear_req,
  output logic [25:0] p_obj1,
  output logic [25:0] p_obj2,
  output logic [25:0] p_obj3,
  output logic [25:0] p_obj4,
  output logic [25:0] p_obj5,
  output logic [2:0]  active_count,
  output logic        busy
);

  localparam int               CNT_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_DIV - 1);

  mgr_state_e       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  desc_t            slot_q [NUM_SLOTS];
  desc_t            slot_d [NUM_SLOTS];
  desc_t            pobj_q [NUM_SLOTS];
  desc_t            pobj_d [NUM_SLOTS];
  logic [4:0]       pending_q, pending_d;
  logic [CNT_W-1:0] anim_cnt_q, anim_cnt_d;
  logic             step_q, step_d;
  logic             vsync_q;
  logic [2:0]       active_q, active_d;

  logic       tick, accept, has_free;
  logic [2:0] free_idx, live_cnt;
  desc_t      cur_desc, next_desc, spawn_desc;

  // End of the active-low sync pulse.
  assign tick        = ~vsync_q & vsync;
  assign spawn_ready = (state_q == ST_IDLE) && has_free;
  assign accept      = spawn_valid && spawn_ready;
  assign busy        = (state_q == ST_UPDATE) || (state_q == ST_PUBLISH);
  assign spawn_desc  = pack_desc('0, spawn_type, HPOS_W'(SPAWN_X), spawn_vpos);

  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    live_cnt = '0;
    cur_desc = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_q[i] == '0) begin
        has_free = 1'b1;
        free_idx = 3'(i);
      end else begin
        live_cnt = live_cnt + 3'd1;
      end
      if (idx_q == 3'(i)) cur_desc = slot_q[i];
    end
  end

  obj_slot_step #(.ANIM_FRAMES(ANIM_FRAMES)) u_step (
    .desc_i  (cur_desc),
    .speed_i (scroll_speed),
    .step_i  (step_q),
    .clear_i (pending_q[idx_q]),
    .desc_o  (next_desc)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    slot_d     = slot_q;
    pobj_d     = pobj_q;
    active_d   = active_q;
    anim_cnt_d = anim_cnt_q;
    step_d     = step_q;
    pending_d  = pending_q | clear_req;

    unique case (state_q)
      ST_IDLE: begin
        // A spawn accepted on the tick edge is written now and updated this frame.
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (accept && free_idx == 3'(i)) slot_d[i] = spawn_desc;
        end
        if (tick) begin
          state_d    = ST_UPDATE;
          idx_d      = '0;
          step_d     = (anim_cnt_q == CNT_LAST);
          anim_cnt_d = (anim_cnt_q == CNT_LAST) ? '0 : anim_cnt_q + CNT_W'(1);
        end
      end
      ST_UPDATE: begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (idx_q == 3'(i)) slot_d[i] = next_desc;
        end
        if (!clear_req[idx_q]) pending_d[idx_q] = 1'b0;
        if (idx_q == 3'(NUM_SLOTS - 1)) state_d = ST_PUBLISH;
        else                           idx_d   = idx_q + 3'd1;
      end
      ST_PUBLISH: begin
        state_d  = ST_IDLE;
        pobj_d   = slot_q;
        active_d = live_cnt;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the slot array is flops, not RAM, and must reset because an
  // all-zero descriptor is what marks a slot empty.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      pending_q  <= '0;
      anim_cnt_q <= '0;
      step_q     <= 1'b0;
      vsync_q    <= 1'b0;
      active_q   <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= '0;
        pobj_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      anim_cnt_q <= anim_cnt_d;
      step_q     <= step_d;
      vsync_q    <= vsync;
      active_q   <= active_d;
      slot_q     <= slot_d;
      pobj_q     <= pobj_d;
    end
  end

  assign p_obj1       = pobj_q[0];
  assign p_obj2       = pobj_q[1];
  assign p_obj3       = pobj_q[2];
  assign p_obj4       = pobj_q[3];
  assign p_obj5       = pobj_q[4];
  assign active_count = active_q;

endmodule

// File: tb/tb_obj_manager.sv
// Directed bench for obj_manager (ANIM_DIV=2, ANIM_FRAMES=3, SPAWN_X=1023);
// expected descriptors are worked out by hand from the frame arithmetic.
module tb_obj_manager;

  logic        vclock = 1'b0;
  logic        reset_n;
  logic        vsync;
  logic [3:0]  scroll_speed;
  logic        spawn_valid;
  logic [1:0]  spawn_type;
  logic [9:0]  spawn_vpos;
  logic        spawn_ready;
  logic [4:0]  clear_req;
  logic [25:0] p_obj1, p_obj2, p_obj3, p_obj4, p_obj5;
  logic [2:0]  active_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  obj_manager #(.SPAWN_X(1023), .ANIM_FRAMES(3), .ANIM_DIV(2)) dut (
    .vclock       (vclock),
    .reset_n      (reset_n),
    .vsync        (vsync),
    .scroll_speed (scroll_speed),
    .spawn_valid  (spawn_valid),
    .spawn_type   (spawn_type),
    .spawn_vpos   (spawn_vpos),
    .spawn_ready  (spawn_ready),
    .clear_req    (clear_req),
    .p_obj1       (p_obj1),
    .p_obj2       (p_obj2),
    .p_obj3       (p_obj3),
    .p_obj4       (p_obj4),
    .p_obj5       (p_obj5),
    .active_count (active_count),
    .busy         (busy)
  );

  always #5 vclock = ~vclock;

  function automatic logic [25:0] mk(input int f, input int id, input int h, input int v);
    return {3'(f), 2'(id), 11'(h), 10'(v)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    vsync       = 1'b0;
    spawn_valid = 1'b0;
    clear_req   = '0;
    repeat (2) @(negedge vclock);
    reset_n = 1'b1;
    @(negedge vclock);
  endtask

  task automatic spawn(input int t, input int v);
    @(negedge vclock);
    spawn_valid = 1'b1;
    spawn_type  = 2'(t);
    spawn_vpos  = 10'(v);
    @(posedge vclock);
    @(negedge vclock);
    spawn_valid = 1'b0;
  endtask

  // Tick edge E0, then E1..E6; returns with the new descriptors published.
  task automatic run_frame();
    @(negedge vclock);
    vsync = 1'b1;
    repeat (7) @(posedge vclock);
    @(negedge vclock);
    vsync = 1'b0;
    @(negedge vclock);
  endtask

  logic [2:0] exp_fr [8];

  initial begin
    exp_fr = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd0, 3'd0, 3'd1};
    scroll_speed = 4'd4;
    spawn_type   = '0;
    spawn_vpos   = '0;

    reset_n = 1'b0;
    vsync = 1'b0;
    spawn_valid = 1'b0;
    clear_req = '0;
    repeat (2) @(negedge vclock);
    check("rst_pobj", {6'd0, p_obj1 | p_obj2 | p_obj3 | p_obj4 | p_obj5}, 32'd0);
    check("rst_active", 32'(active_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    @(negedge vclock);
    check("rst_ready", 32'(spawn_ready), 32'd1);

    // First spawn and frame, with latency checks along the way.
    spawn(1, 300);
    @(negedge vclock);
    vsync = 1'b1;
    @(posedge vclock);
    @(negedge vclock);
    check("e1_busy", 32'(busy), 32'd1);
    check("e1_ready", 32'(spawn_ready), 32'd0);
    repeat (5) @(posedge vclock);
    @(negedge vclock);
    check("e5_pobj1_hold", 32'(p_obj1), 32'd0);
    check("e5_ready", 32'(spawn_ready), 32'd0);
    @(posedge vclock);
    @(negedge vclock);
    check("f1_pobj1", 32'(p_obj1), 32'(mk(0, 1, 1019, 300)));
    check("f1_active", 32'(active_count), 32'd1);
    check("f1_busy", 32'(busy), 32'd0);
    check("f1_ready", 32'(spawn_ready), 32'd1);
    vsync = 1'b0;
    @(negedge vclock);

    // Fill, clear slot 2, respawn into it.
    spawn(0, 10);
    spawn(0, 20);
    spawn(0, 30);
    spawn(0, 40);
    check("full_ready", 32'(spawn_ready), 32'd0);
    @(negedge vclock);
    clear_req = 5'b00100;
    @(negedge vclock);
    clear_req = '0;
    run_frame();
    check("f2_pobj3", 32'(p_obj3), 32'd0);
    check("f2_pobj1", 32'(p_obj1), 32'(mk(1, 1, 1015, 300)));
    check("f2_pobj2", 32'(p_obj2), 32'(mk(1, 0, 1019, 10)));
    check("f2_active", 32'(active_count), 32'd4);
    check("f2_ready", 32'(spawn_ready), 32'd1);
    spawn(1, 77);
    check("respawn_full", 32'(spawn_ready), 32'd0);
    check("respawn_nopub", 32'(p_obj3), 32'd0);
    run_frame();
    check("f3_pobj3", 32'(p_obj3), 32'(mk(0, 1, 1019, 77)));
    check("f3_active", 32'(active_count), 32'd5);

    // Held spawn while full is taken right after the freeing frame publishes.
    @(negedge vclock);
    spawn_valid = 1'b1;
    spawn_type  = 2'd0;
    spawn_vpos  = 10'd5;
    clear_req   = 5'b10000;
    @(negedge vclock);
    clear_req = '0;
    run_frame();
    spawn_valid = 1'b0;
    check("f4_pobj5", 32'(p_obj5), 32'd0);
    check("f4_active", 32'(active_count), 32'd4);
    check("f4_held_taken", 32'(spawn_ready), 32'd0);

    // hpos 3 with speed 4 retires the object.
    do_reset();
    scroll_speed = 4'd15;
    spawn(1, 100);
    for (int n = 0; n < 68; n++) run_frame();
    check("h3_hpos", 32'(p_obj1[20:10]), 32'd3);
    scroll_speed = 4'd4;
    run_frame();
    check("h3_gone", 32'(p_obj1), 32'd0);
    check("h3_active", 32'(active_count), 32'd0);

    // hpos 4 with speed 4 lands on hpos 0 and stays live.
    scroll_speed = 4'd15;
    spawn(1, 100);
    for (int n = 0; n < 67; n++) run_frame();
    scroll_speed = 4'd14;
    run_frame();
    check("h4_hpos", 32'(p_obj1[20:10]), 32'd4);
    scroll_speed = 4'd4;
    run_frame();
    check("h0_hpos", 32'(p_obj1[20:10]), 32'd0);
    check("h0_nonzero", 32'(p_obj1 != '0), 32'd1);
    check("h0_active", 32'(active_count), 32'd1);

    // Animation sequence with ANIM_DIV=2, ANIM_FRAMES=3.
    do_reset();
    scroll_speed = 4'd1;
    spawn(0, 50);
    for (int k = 0; k < 8; k++) begin
      run_frame();
      check($sformatf("anim_t%0d", k + 1), 32'(p_obj1[25:23]), 32'(exp_fr[k]));
    end

    // Spawn on the tick edge; clear for slot 0 at E3 waits a frame.
    do_reset();
    scroll_speed = 4'd4;
    @(negedge vclock);
    vsync       = 1'b1;
    spawn_valid = 1'b1;
    spawn_type  = 2'd0;
    spawn_vpos  = 10'd200;
    @(posedge vclock);
    @(negedge vclock);
    spawn_valid = 1'b0;
    repeat (2) @(posedge vclock);
    @(negedge vclock);
    clear_req = 5'b00001;
    @(posedge vclock);
    @(negedge vclock);
    clear_req = '0;
    repeat (3) @(posedge vclock);
    @(negedge vclock);
    check("same_pobj1", 32'(p_obj1), 32'(mk(0, 0, 1019, 200)));
    check("same_active", 32'(active_count), 32'd1);
    vsync = 1'b0;
    @(negedge vclock);
    run_frame();
    check("late_clear", 32'(p_obj1), 32'd0);
    check("late_active", 32'(active_count), 32'd0);

    // Reset in the middle of UPDATE.
    spawn(1, 300);
    run_frame();
    check("pre_rst_pobj1", 32'(p_obj1), 32'(mk(0, 1, 1019, 300)));
    @(negedge vclock);
    vsync = 1'b1;
    repeat (4) @(posedge vclock);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_pobj", {6'd0, p_obj1 | p_obj2 | p_obj3 | p_obj4 | p_obj5}, 32'd0);
    check("mid_rst_active", 32'(active_count), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    vsync = 1'b0;
    @(negedge vclock);
    @(negedge vclock);
    reset_n = 1'b1;
    @(negedge vclock);
    run_frame();
    check("post_rst_pobj", {6'd0, p_obj1 | p_obj2 | p_obj3 | p_obj4 | p_obj5}, 32'd0);
    check("post_rst_active", 32'(active_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
